// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Each accepted operation takes three cycles: the grant cycle (IDLE), one
// cycle for the ALU to settle on the registered operands (EXEC), and at
// least one response cycle (RESP) that holds until the consumer takes it.
// Arbitration is round-robin (RR=1) or fixed priority to requester 0 (RR=0).

module alu_arbiter #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_flg,

  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_flg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q;
  logic       lastGrant_q;
  logic [7:0] operandA_q;
  logic [7:0] operandB_q;
  logic [3:0] operandOp_q;
  logic       rspValid_q;
  logic       rspId_q;
  logic [7:0] rspData_q;
  logic [7:0] rspFlg_q;

  logic       grantAny;
  logic       grantSel;
  logic [7:0] selA;
  logic [7:0] selB;
  logic [3:0] selOp;

  // Pick a winner in IDLE; the reset term keeps both readys low while rst is high even if a request is pending.
  always_comb begin
    grantAny = 1'b0;
    grantSel = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        grantAny = 1'b1;
        grantSel = RR ? ~lastGrant_q : 1'b0;
      end else if (req0_valid) begin
        grantAny = 1'b1;
        grantSel = 1'b0;
      end else if (req1_valid) begin
        grantAny = 1'b1;
        grantSel = 1'b1;
      end
    end
  end

  // Steer the winning requester's operands toward the operand registers.
  always_comb begin
    selA  = req0_a;
    selB  = req0_b;
    selOp = req0_op;
    if (grantSel) begin
      selA  = req1_a;
      selB  = req1_b;
      selOp = req1_op;
    end
  end

  assign req0_ready = grantAny && !grantSel;
  assign req1_ready = grantAny && grantSel;

  // Single FSM process: state, arbitration pointer, operand capture and the registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      operandA_q  <= 8'h00;
      operandB_q  <= 8'h00;
      operandOp_q <= 4'h0;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspData_q   <= 8'h00;
      rspFlg_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantAny) begin
            operandA_q  <= selA;
            operandB_q  <= selB;
            operandOp_q <= selOp;
            rspId_q     <= grantSel;
            lastGrant_q <= grantSel;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          rspData_q  <= alu_out;
          rspFlg_q   <= alu_flg;
          rspValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rspValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign alu_a     = operandA_q;
  assign alu_b     = operandB_q;
  assign alu_op    = operandOp_q;
  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_data  = rspData_q;
  assign rsp_flg   = rspFlg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a round-robin instance driven by directed and
// random traffic against a cycle-level transaction model, plus a
// fixed-priority instance exercised under contention.

module tb_alu_arbiter;

  localparam bit RR_MAIN = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       req0Valid, req1Valid, req0Ready, req1Ready;
  logic [7:0] req0A, req0B, req1A, req1B;
  logic [3:0] req0Op, req1Op;
  logic [7:0] aluA, aluB, aluOut, aluFlg;
  logic [3:0] aluOp;
  logic       rspValid, rspReady, rspId;
  logic [7:0] rspData, rspFlg;

  logic       fReq0Valid, fReq1Valid, fReq0Ready, fReq1Ready;
  logic [7:0] fReq0A, fReq0B, fReq1A, fReq1B;
  logic [3:0] fReq0Op, fReq1Op;
  logic [7:0] fAluA, fAluB, fAluOut, fAluFlg;
  logic [3:0] fAluOp;
  logic       fRspValid, fRspReady, fRspId;
  logic [7:0] fRspData, fRspFlg;

  int assertCount = 0;
  int failCount   = 0;

  // transaction-level model of the round-robin instance
  bit         mBusy;
  int         mLast;
  int         mGrantCycle;
  int         mId;
  logic [7:0] mA, mB, mData, mFlg;
  logic [3:0] mOp;
  int         cycleIdx = 0;
  int         gLog[$];
  int         gCyc[$];
  int         fpLog[$];

  alu_arbiter #(.RR(1'b1)) dutRr (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_ready(req0Ready), .req0_a(req0A), .req0_b(req0B), .req0_op(req0Op),
    .req1_valid(req1Valid), .req1_ready(req1Ready), .req1_a(req1A), .req1_b(req1B), .req1_op(req1Op),
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_out(aluOut), .alu_flg(aluFlg),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId), .rsp_data(rspData), .rsp_flg(rspFlg)
  );

  alu_arbiter #(.RR(1'b0)) dutFp (
    .clk(clk), .rst(rst),
    .req0_valid(fReq0Valid), .req0_ready(fReq0Ready), .req0_a(fReq0A), .req0_b(fReq0B), .req0_op(fReq0Op),
    .req1_valid(fReq1Valid), .req1_ready(fReq1Ready), .req1_a(fReq1A), .req1_b(fReq1B), .req1_op(fReq1Op),
    .alu_a(fAluA), .alu_b(fAluB), .alu_op(fAluOp), .alu_out(fAluOut), .alu_flg(fAluFlg),
    .rsp_valid(fRspValid), .rsp_ready(fRspReady), .rsp_id(fRspId), .rsp_data(fRspData), .rsp_flg(fRspFlg)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0000 ADD, 1000 SUB, 0001 AND, 0010 OR, others XOR.
  function automatic logic [7:0] aluResult(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a & b;
      4'b0010: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Flags: [7]=0, [6]=1, [3]=zero, [2]=negative, [0]=carry/borrow.
  function automatic logic [7:0] aluFlags(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] wide;
    logic [7:0] r;
    case (op)
      4'b0000: wide = {1'b0, a} + {1'b0, b};
      4'b1000: wide = {1'b0, a} - {1'b0, b};
      default: wide = {1'b0, aluResult(a, b, op)};
    endcase
    r = wide[7:0];
    return {1'b0, 1'b1, 2'b00, (r == 8'h00), r[7], 1'b0, wide[8]};
  endfunction

  // The two ALU instances the arbiters drive.
  always_comb begin
    aluOut  = aluResult(aluA, aluB, aluOp);
    aluFlg  = aluFlags(aluA, aluB, aluOp);
    fAluOut = aluResult(fAluA, fAluB, fAluOp);
    fAluFlg = aluFlags(fAluA, fAluB, fAluOp);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic newOp(output logic [7:0] a, output logic [7:0] b, output logic [3:0] op);
    a = 8'($urandom);
    b = 8'($urandom);
    case ($urandom_range(0, 3))
      0:       op = 4'b0000;
      1:       op = 4'b1000;
      2:       op = 4'($urandom_range(1, 3));
      default: op = 4'($urandom_range(0, 15));
    endcase
  endtask

  task automatic captureGrant(input int w, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    mBusy       = 1'b1;
    mGrantCycle = cycleIdx;
    mLast       = w;
    mId         = w;
    mA          = a;
    mB          = b;
    mOp         = op;
    mData       = aluResult(a, b, op);
    mFlg        = aluFlags(a, b, op);
  endtask

  // One clock of the round-robin instance: check against the model, then advance it.
  // Called and returns at one time unit after a rising edge.
  task automatic applyStimulus();
    int win;
    bit rspExp;
    #1;
    win = -1;
    if (!mBusy) begin
      if (req0Valid && req1Valid) win = (RR_MAIN && mLast == 0) ? 1 : 0;
      else if (req0Valid)         win = 0;
      else if (req1Valid)         win = 1;
    end
    rspExp = mBusy && ((cycleIdx - mGrantCycle) >= 2);
    if (req0Ready) begin gLog.push_back(0); gCyc.push_back(cycleIdx); end
    if (req1Ready) begin gLog.push_back(1); gCyc.push_back(cycleIdx); end
    checkOutput("req0_ready", 32'(req0Ready), 32'(win == 0));
    checkOutput("req1_ready", 32'(req1Ready), 32'(win == 1));
    checkOutput("rsp_valid", 32'(rspValid), 32'(rspExp));
    checkOutput("alu_a", 32'(aluA), 32'(mA));
    checkOutput("alu_b", 32'(aluB), 32'(mB));
    checkOutput("alu_op", 32'(aluOp), 32'(mOp));
    if (rspExp) begin
      checkOutput("rsp_id", 32'(rspId), mId);
      checkOutput("rsp_data", 32'(rspData), 32'(mData));
      checkOutput("rsp_flg", 32'(rspFlg), 32'(mFlg));
    end
    @(posedge clk);
    #1;
    if (win == 0) begin
      captureGrant(0, req0A, req0B, req0Op);
      req0Valid = 1'b0;
    end else if (win == 1) begin
      captureGrant(1, req1A, req1B, req1Op);
      req1Valid = 1'b0;
    end else if (rspExp && rspReady) begin
      mBusy = 1'b0;
    end
    cycleIdx++;
  endtask

  // Assert reset between edges, check that outputs clear at once, then release.
  task automatic doReset();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_req0_ready", 32'(req0Ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1Ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rspId), 32'd0);
    checkOutput("rst_rsp_data", 32'(rspData), 32'd0);
    checkOutput("rst_rsp_flg", 32'(rspFlg), 32'd0);
    checkOutput("rst_alu_a", 32'(aluA), 32'd0);
    checkOutput("rst_alu_b", 32'(aluB), 32'd0);
    checkOutput("rst_alu_op", 32'(aluOp), 32'd0);
    checkOutput("rst_fp_rsp_valid", 32'(fRspValid), 32'd0);
    checkOutput("rst_fp_req_ready", 32'({fReq0Ready, fReq1Ready}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    mBusy = 1'b0;
    mLast = 1;
    mA    = 8'h00;
    mB    = 8'h00;
    mOp   = 4'h0;
    mId   = 0;
  endtask

  initial begin
    logic [7:0] fSaveA, fSaveB;
    logic [3:0] fSaveOp;
    req0Valid = 1'b0; req1Valid = 1'b0; rspReady = 1'b0;
    req0A = 8'h00; req0B = 8'h00; req0Op = 4'h0;
    req1A = 8'h00; req1B = 8'h00; req1Op = 4'h0;
    fReq0Valid = 1'b0; fReq1Valid = 1'b0; fRspReady = 1'b0;
    fReq0A = 8'h00; fReq0B = 8'h00; fReq0Op = 4'h0;
    fReq1A = 8'h00; fReq1B = 8'h00; fReq1Op = 4'h0;
    fSaveA = 8'h00; fSaveB = 8'h00; fSaveOp = 4'h0;
    #1;
    doReset();

    $display("[TB] single ADD from requester 0");
    req0A = 8'h12; req0B = 8'h34; req0Op = 4'b0000; req0Valid = 1'b1;
    rspReady = 1'b1;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("single_valid", 32'(rspValid), 32'd1);
    checkOutput("single_id", 32'(rspId), 32'd0);
    checkOutput("single_data", 32'(rspData), 32'h46);
    checkOutput("single_zflag", 32'(rspFlg[3]), 32'd0);
    applyStimulus();
    applyStimulus();

    $display("[TB] zero-result SUB from requester 1");
    req1A = 8'h05; req1B = 8'h05; req1Op = 4'b1000; req1Valid = 1'b1;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("zero_id", 32'(rspId), 32'd1);
    checkOutput("zero_data", 32'(rspData), 32'h00);
    checkOutput("zero_zflag", 32'(rspFlg[3]), 32'd1);
    checkOutput("zero_flg6", 32'(rspFlg[6]), 32'd1);
    applyStimulus();
    applyStimulus();

    $display("[TB] backpressure in RESP");
    newOp(req0A, req0B, req0Op); req0Valid = 1'b1;
    rspReady = 1'b0;
    applyStimulus();
    applyStimulus();
    newOp(req1A, req1B, req1Op); req1Valid = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus();
    rspReady = 1'b1;
    applyStimulus();
    #1;
    checkOutput("bp_next_grant", 32'(req1Ready), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus();

    $display("[TB] reset during EXEC");
    newOp(req0A, req0B, req0Op); req0Valid = 1'b1;
    applyStimulus();
    newOp(req1A, req1B, req1Op); req1Valid = 1'b1;
    doReset();
    checkOutput("post_rst_no_stale", 32'(rspValid), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus();

    $display("[TB] round-robin contention");
    doReset();
    gLog.delete(); gCyc.delete();
    rspReady = 1'b1;
    for (int c = 0; c < 20 && gLog.size() < 4; c++) begin
      if (!req0Valid) begin newOp(req0A, req0B, req0Op); req0Valid = 1'b1; end
      if (!req1Valid) begin newOp(req1A, req1B, req1Op); req1Valid = 1'b1; end
      applyStimulus();
    end
    checkOutput("rr_grant_count", gLog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rr_order_%0d", i), (i < gLog.size()) ? gLog[i] : 99, i % 2);
    checkOutput("rr_issue_interval", (gCyc.size() >= 2) ? gCyc[1] - gCyc[0] : -1, 3);
    req0Valid = 1'b0; req1Valid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();

    $display("[TB] fixed-priority contention");
    fRspReady = 1'b1;
    newOp(fReq0A, fReq0B, fReq0Op); fReq0Valid = 1'b1;
    newOp(fReq1A, fReq1B, fReq1Op); fReq1Valid = 1'b1;
    fpLog.delete();
    for (int c = 0; c < 16 && fpLog.size() < 4; c++) begin
      #1;
      checkOutput("fp_req1_ready", 32'(fReq1Ready), 32'd0);
      if (fRspValid) begin
        checkOutput("fp_rsp_id", 32'(fRspId), 32'd0);
        checkOutput("fp_rsp_data", 32'(fRspData), 32'(aluResult(fSaveA, fSaveB, fSaveOp)));
        checkOutput("fp_rsp_flg", 32'(fRspFlg), 32'(aluFlags(fSaveA, fSaveB, fSaveOp)));
      end
      if (fReq0Ready) begin
        fpLog.push_back(0);
        fSaveA = fReq0A; fSaveB = fReq0B; fSaveOp = fReq0Op;
      end
      if (fReq1Ready) fpLog.push_back(1);
      @(posedge clk);
      #1;
      if (fpLog.size() > 0 && fSaveA == fReq0A && fSaveB == fReq0B && fSaveOp == fReq0Op)
        newOp(fReq0A, fReq0B, fReq0Op);
    end
    checkOutput("fp_grant_count", fpLog.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("fp_order_%0d", i), (i < fpLog.size()) ? fpLog[i] : 99, 0);
    fReq0Valid = 1'b0; fReq1Valid = 1'b0;

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if (!req0Valid && $urandom_range(0, 2) == 0) begin newOp(req0A, req0B, req0Op); req0Valid = 1'b1; end
      if (!req1Valid && $urandom_range(0, 2) == 0) begin newOp(req1A, req1B, req1Op); req1Valid = 1'b1; end
      rspReady = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    req0Valid = 1'b0; req1Valid = 1'b0; rspReady = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("drain_idle", 32'(rspValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
